// File: rtl/ebi_ram_arbiter.sv
// rtl/ebi_ram_arbiter.sv - shares one single-port RAM between the host EBI side and an internal requester (optional IRQ: EBI_RAM_ARBITER_IRQ_EN)
module ebi_ram_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  host_req_i,
    input  logic                  host_we_i,
    input  logic [ADDR_WIDTH-1:0] host_addr_i,
    input  logic [DATA_WIDTH-1:0] host_data_i,
    output logic                  host_ack_o,
    output logic [DATA_WIDTH-1:0] host_data_o,
    input  logic                  int_req_i,
    input  logic                  int_we_i,
    input  logic [ADDR_WIDTH-1:0] int_addr_i,
    input  logic [DATA_WIDTH-1:0] int_data_i,
    output logic                  int_ack_o,
    output logic [DATA_WIDTH-1:0] int_data_o,
    output logic                  ram_rd_o,
    output logic                  ram_wr_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    output logic                  busy_o,
    output logic                  irq_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t           state;
    logic             win_int;     // latched winner: 1 = internal, 0 = host
    logic             lat_we;      // latched direction of the current transaction
    logic [CNT_W-1:0] starve_cnt;  // host grants made while the internal side waited

    logic             any_req;
    logic             pick_int;
    logic             sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // Fixed-priority pick: host first, unless the internal side has waited out its budget
    always_comb begin
        any_req  = host_req_i | int_req_i;
        pick_int = 1'b0;
        if (int_req_i && (!host_req_i || (starve_cnt == CNT_MAX))) begin
            pick_int = 1'b1;
        end
        sel_we   = pick_int ? int_we_i   : host_we_i;
        sel_addr = pick_int ? int_addr_i : host_addr_i;
        sel_data = pick_int ? int_data_i : host_data_i;
    end

    // Transaction sequencer; every output is a register so the RAM pins stay glitch-free
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= IDLE;
            win_int     <= 1'b0;
            lat_we      <= 1'b0;
            starve_cnt  <= '0;
            host_ack_o  <= 1'b0;
            int_ack_o   <= 1'b0;
            host_data_o <= '0;
            int_data_o  <= '0;
            ram_rd_o    <= 1'b0;
            ram_wr_o    <= 1'b0;
            ram_addr_o  <= '0;
            ram_data_o  <= '0;
            busy_o      <= 1'b0;
        end else begin
            // acks and strobes are single-cycle unless a state below raises them
            host_ack_o <= 1'b0;
            int_ack_o  <= 1'b0;
            ram_rd_o   <= 1'b0;
            ram_wr_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        win_int    <= pick_int;
                        lat_we     <= sel_we;
                        ram_addr_o <= sel_addr;
                        ram_data_o <= sel_data;
                        ram_wr_o   <= sel_we;
                        ram_rd_o   <= ~sel_we;
                        busy_o     <= 1'b1;
                        state      <= ISSUE;
                        if (pick_int) begin
                            starve_cnt <= '0;
                        end else if (int_req_i && (starve_cnt != CNT_MAX)) begin
                            starve_cnt <= starve_cnt + CNT_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    if (lat_we) begin
                        // writes complete as soon as the strobe has been presented
                        state <= ACK;
                        if (win_int) begin
                            int_ack_o <= 1'b1;
                        end else begin
                            host_ack_o <= 1'b1;
                        end
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // RAM read data is valid now; only the winner's register moves
                    state <= ACK;
                    if (win_int) begin
                        int_data_o <= ram_data_i;
                        int_ack_o  <= 1'b1;
                    end else begin
                        host_data_o <= ram_data_i;
                        host_ack_o  <= 1'b1;
                    end
                end
                ACK: begin
                    // always return through IDLE so a held request is re-arbitrated
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef EBI_RAM_ARBITER_IRQ_EN
    logic irq_q;
    logic ack_next;

    // The edge that raises an ack is the one entering ACK
    always_comb begin
        ack_next = ((state == ISSUE) && lat_we) || (state == WAIT);
    end

    // Sticky flag: internal writes set it, host accesses clear it, set has priority
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            irq_q <= 1'b0;
        end else if (ack_next) begin
            if (win_int && lat_we) begin
                irq_q <= 1'b1;
            end else if (!win_int) begin
                irq_q <= 1'b0;
            end
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_ebi_ram_arbiter.sv
// tb/tb_ebi_ram_arbiter.sv - directed self-checking bench for ebi_ram_arbiter
module tb_ebi_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_req, host_we, host_ack;
    logic [4:0]  host_addr;
    logic [15:0] host_wdata, host_rdata;
    logic        int_req, int_we, int_ack;
    logic [4:0]  int_addr;
    logic [15:0] int_wdata, int_rdata;
    logic        ram_rd, ram_wr, busy, irq;
    logic [4:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    int n_assert = 0;
    int n_fail   = 0;
    int host_pulses = 0;

    logic [15:0] mem [32];

`ifdef EBI_RAM_ARBITER_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    ebi_ram_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .STARVE_LIMIT(4)) dut (
        .clk_i(clk), .reset_i(rst),
        .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
        .host_data_i(host_wdata), .host_ack_o(host_ack), .host_data_o(host_rdata),
        .int_req_i(int_req), .int_we_i(int_we), .int_addr_i(int_addr),
        .int_data_i(int_wdata), .int_ack_o(int_ack), .int_data_o(int_rdata),
        .ram_rd_o(ram_rd), .ram_wr_o(ram_wr), .ram_addr_o(ram_addr),
        .ram_data_o(ram_wdata), .ram_data_i(ram_rdata),
        .busy_o(busy), .irq_o(irq)
    );

    // RAM model: read data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_wdata;
        if (ram_rd) ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Always-on protocol checker
    logic prev_hack = 1'b0, prev_iack = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_rd || ram_wr) chk("strobe_excl", {31'd0, ram_rd & ram_wr}, 32'd0);
            if (prev_hack) chk("host_ack_width", {31'd0, host_ack}, 32'd0);
            if (prev_iack) chk("int_ack_width", {31'd0, int_ack}, 32'd0);
            if (host_ack) host_pulses++;
        end
        prev_hack = host_ack & ~rst;
        prev_iack = int_ack & ~rst;
    end

    logic        s_rd, s_wr, s_irq;
    logic [4:0]  s_addr;
    logic [15:0] s_data;

    // One transaction from IDLE; lat counts cycles from the sampling edge to the ack
    task automatic xfer(input bit side, input bit we, input logic [4:0] a,
                        input logic [15:0] d, output int lat, output logic [15:0] rd);
        if (side) begin int_req = 1; int_we = we; int_addr = a; int_wdata = d; end
        else begin host_req = 1; host_we = we; host_addr = a; host_wdata = d; end
        lat = 0;
        rd = '0;
        s_irq = 1'b0;
        while (lat <= 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                s_rd = ram_rd; s_wr = ram_wr; s_addr = ram_addr; s_data = ram_wdata;
            end
            if (side ? int_ack : host_ack) break;
        end
        rd = side ? int_rdata : host_rdata;
        s_irq = irq;
        host_req = 0;
        int_req = 0;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        logic [15:0] rd;
        logic [9:0] order;
        int grants;
        int cyc;
        int acks;
        int pulses0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        ram_rdata = '0;
        rst = 1;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        int_req = 0; int_we = 0; int_addr = 0; int_wdata = 0;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_strobes", {30'd0, ram_rd, ram_wr}, 0);
        chk("rst_acks", {30'd0, host_ack, int_ack}, 0);
        chk("rst_hdata", {16'd0, host_rdata}, 0);
        chk("rst_idata", {16'd0, int_rdata}, 0);
        chk("rst_addr", {27'd0, ram_addr}, 0);
        chk("rst_irq", {31'd0, irq}, 0);
        rst = 0;
        @(negedge clk);

        // host write then read back
        xfer(0, 1, 5'd5, 16'hBEEF, lat, rd);
        chk("hw_lat", lat, 2);
        chk("hw_wr", {30'd0, s_wr, s_rd}, 32'd2);
        chk("hw_addr", {27'd0, s_addr}, 5);
        chk("hw_data", {16'd0, s_data}, 32'hBEEF);
        chk("hw_idle", {31'd0, busy}, 0);
        xfer(0, 0, 5'd5, 16'h0000, lat, rd);
        chk("hr_lat", lat, 3);
        chk("hr_rd", {30'd0, s_wr, s_rd}, 32'd1);
        chk("hr_addr", {27'd0, s_addr}, 5);
        chk("hr_data", {16'd0, rd}, 32'hBEEF);
        chk("hr_hold", {16'd0, host_rdata}, 32'hBEEF);
        chk("hr_loser", {16'd0, int_rdata}, 0);

        // both requesters held high: four host grants per internal grant
        host_req = 1; host_we = 1; host_addr = 5'd1; host_wdata = 16'h1111;
        int_req = 1; int_we = 1; int_addr = 5'd2; int_wdata = 16'h2222;
        grants = 0; cyc = 0; order = '0;
        while (grants < 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (host_ack && int_ack) chk("both_ack", 1, 0);
            if (host_ack || int_ack) begin
                order[9 - grants] = host_ack;
                grants++;
            end
        end
        host_req = 0; int_req = 0;
        chk("starve_grants", grants, 10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("grant_%0d", i), {31'd0, order[9 - i]}, (i == 4 || i == 9) ? 0 : 1);
        @(negedge clk);
        @(negedge clk);
        chk("starve_idle", {31'd0, busy}, 0);

        // internal-only fill and readback
        pulses0 = host_pulses;
        for (int a = 0; a < 32; a++) begin
            xfer(1, 1, 5'(a), 16'(a) ^ 16'h5A5A, lat, rd);
            chk($sformatf("iw_lat_%0d", a), lat, 2);
        end
        for (int a = 0; a < 32; a++) begin
            xfer(1, 0, 5'(a), 16'h0, lat, rd);
            chk($sformatf("ir_lat_%0d", a), lat, 3);
            chk($sformatf("ir_data_%0d", a), {16'd0, rd}, {16'd0, 16'(a) ^ 16'h5A5A});
        end
        chk("no_host_ack", host_pulses - pulses0, 0);

        // reset during ISSUE of a host read
        host_req = 1; host_we = 0; host_addr = 5'd3;
        @(posedge clk);
        #2;
        chk("pre_rst_rd", {31'd0, ram_rd}, 1);
        chk("pre_rst_busy", {31'd0, busy}, 1);
        rst = 1;
        #1;
        chk("async_rd", {31'd0, ram_rd}, 0);
        chk("async_busy", {31'd0, busy}, 0);
        host_req = 0;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (host_ack || int_ack) acks++;
        end
        rst = 0;
        repeat (2) begin
            @(negedge clk);
            if (host_ack || int_ack) acks++;
        end
        chk("rst_no_ack", acks, 0);
        chk("rst_hdata_clr", {16'd0, host_rdata}, 0);
        chk("rst_irq_clr", {31'd0, irq}, 0);
        xfer(0, 0, 5'd3, 16'h0, lat, rd);
        chk("reissue_lat", lat, 3);
        chk("reissue_data", {16'd0, rd}, 32'h5A59);

        // interrupt: internal write sets, host access clears
        xfer(1, 1, 5'd7, 16'h1234, lat, rd);
        chk("irq_set_ack", {31'd0, s_irq}, {31'd0, IRQ_EN});
        chk("irq_sticky", {31'd0, irq}, {31'd0, IRQ_EN});
        xfer(0, 0, 5'd7, 16'h0, lat, rd);
        chk("irq_hr_data", {16'd0, rd}, 32'h1234);
        chk("irq_clr_ack", {31'd0, s_irq}, 0);
        chk("irq_clr_after", {31'd0, irq}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ebi_ram_arbiter.md
Name: ebi_ram_arbiter

Overview:
- Sequences and shares the single-port SimpleRam between two requesters:
  - the host side, i.e. synchronized EBI strobes from the AT91 bus interface;
  - an internal fabric requester.
- Owns the RAM strobes, address and write data.
- Fixed-priority arbitration with a starvation guard.
- Registered read-data return.

Parameters:
- DATA_WIDTH, 16, width of the RAM word and of both requester data paths.
- ADDR_WIDTH, 5, RAM word-address width (32 cells).
- STARVE_LIMIT, 4, consecutive host grants allowed while int_req_i is pending.

Ports:
- clk_i  in  1  single system clock.
- reset_i  in  1  asynchronous, active-high reset.
- host_req_i  in  1  host request; held high until host_ack_o.
- host_we_i  in  1  1 = write, 0 = read; stable while host_req_i is high.
- host_addr_i  in  ADDR_WIDTH  host word address.
- host_data_i  in  DATA_WIDTH  host write data.
- host_ack_o  out  1  one-cycle completion pulse.
- host_data_o  out  DATA_WIDTH  host read data; valid with host_ack_o, held until the next host read.
- int_req_i, int_we_i, int_addr_i, int_data_i  in  1/1/ADDR_WIDTH/DATA_WIDTH  internal requester; same rules as host.
- int_ack_o  out  1  one-cycle completion pulse.
- int_data_o  out  DATA_WIDTH  internal read data; same rules as host_data_o.
- ram_rd_o  out  1  RAM read strobe, active-high.
- ram_wr_o  out  1  RAM write strobe, active-high.
- ram_addr_o  out  ADDR_WIDTH  RAM address.
- ram_data_o  out  DATA_WIDTH  RAM write data.
- ram_data_i  in  DATA_WIDTH  RAM read data; valid the cycle after ram_rd_o.
- busy_o  out  1  high in any state other than IDLE.
- irq_o  out  1  see Optional Feature.

Behaviour:
- Reset (asynchronous, immediate):
  - FSM to IDLE;
  - all outputs 0, including data registers and the starvation counter;
  - an in-flight transaction is dropped with no ack; requesters re-issue after reset.
- FSM states: IDLE, ISSUE, WAIT, ACK. All outputs are registered.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If any request is pending, latch winner id, we, addr and data, then go to ISSUE.
- Arbitration in IDLE:
  - Only host_req_i high: host wins.
  - Only int_req_i high: internal wins.
  - Both high: host wins unless starve_cnt == STARVE_LIMIT, in which case internal wins.
  - starve_cnt increments on each host grant made while int_req_i is high, saturating at STARVE_LIMIT.
  - starve_cnt clears on any internal grant.
- ISSUE (exactly 1 cycle):
  - ram_addr_o and ram_data_o drive the latched values.
  - Exactly one of ram_rd_o / ram_wr_o is high.
  - Write: go to ACK. Read: go to WAIT.
- WAIT (read only):
  - Strobes are low.
  - Capture ram_data_i into the winner's data_o register at the end of the cycle.
  - Go to ACK.
- ACK (1 cycle):
  - The winner's ack output is high.
  - The loser's ack and data outputs are unchanged.
  - Go to IDLE.
- Latency, with the request sampled in IDLE at cycle N:
  - write: ram_wr_o at N+1, ack at N+2;
  - read: ram_rd_o at N+1, data captured at N+2, ack + data at N+3.
- At least one IDLE cycle follows every ACK. A request still high in that IDLE cycle is treated as a new request. Requesters must drop req the cycle after ack.
- ram_rd_o and ram_wr_o are never high together, and never high outside ISSUE.
- A request that drops before its ack is a protocol violation. The latched transaction still completes and is still acked.

Optional Feature:
- Macro: EBI_RAM_ARBITER_IRQ_EN.
- With the macro defined:
  - irq_o is a sticky level, set at the ACK of every internal write;
  - irq_o is cleared at the ACK of any host access;
  - if both happen in the same ACK cycle, set wins;
  - reset value is 0.
- Without the macro: irq_o is tied to 0 and no IRQ logic is built.

Test Plan:
- Host write addr 5, data 0xBEEF at cycle N: ram_wr_o=1, ram_addr_o=5, ram_data_o=0xBEEF at N+1; host_ack_o at N+2. Then host read addr 5: host_data_o=0xBEEF with host_ack_o at N'+3.
- Both requests high continuously with STARVE_LIMIT=4: grant order is H,H,H,H,I,H,H,H,H,I. int_ack_o appears after exactly 4 host acks.
- Only internal requests, addresses 0..31 written with value addr^0x5A5A then read back: all 32 reads return the written values; host_ack_o never pulses.
- Assert reset_i during the ISSUE of a read:
  - strobes and busy_o go to 0 immediately, without waiting for a clock edge;
  - no ack is produced;
  - after reset releases, a reissued read completes normally.
- Checker over all tests: ram_rd_o & ram_wr_o is never 1, and each ack is exactly one cycle wide.
- With EBI_RAM_ARBITER_IRQ_EN: internal write completes -> irq_o=1 from the ACK cycle onward; the next host read ack -> irq_o=0. Without the macro, irq_o stays 0 throughout.
